// File: rtl/i2s_rx_deser.sv
// I2S line-in receiver: codec clock generation, 24-bit L/R deserialization and
// a small valid/ready output FIFO. Define I2S_RX_OVF_COUNT_EN to add ovf_count_o.
module i2s_rx_deser #(
  parameter int unsigned width_p      = 24,
  parameter int unsigned fifo_depth_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  output logic               rx_main_clk_o,
  output logic               rx_data_clk_o,
  output logic               rx_lr_clk_o,
  input  logic               rx_data_i,
  output logic [width_p-1:0] data_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               last_o,
  output logic               overflow_o
`ifdef I2S_RX_OVF_COUNT_EN
  ,
  output logic [15:0]        ovf_count_o
`endif
);

  localparam int unsigned              ptr_w_lp    = $clog2(fifo_depth_p);
  localparam logic [4:0]               last_bit_lp = 5'(width_p);
  localparam logic [ptr_w_lp:0]        depth_lp    = (ptr_w_lp+1)'(fifo_depth_p);

  logic [8:0]          count_r;
  logic [1:0]          sync_r;
  logic [width_p-1:0]  shift_r;
  logic [width_p:0]    mem_r [fifo_depth_p];
  logic [ptr_w_lp-1:0] wr_ptr_r;
  logic [ptr_w_lp-1:0] rd_ptr_r;
  logic [ptr_w_lp:0]   occ_r;
  logic                overflow_r;

  logic       ch;
  logic [4:0] bit_idx;
  logic [2:0] phase;
  logic       capture;
  logic       push;
  logic       pop;
  logic       full;
  logic       accept;
  logic       drop;

  assign ch      = count_r[8];
  assign bit_idx = count_r[7:3];
  assign phase   = count_r[2:0];

  assign rx_main_clk_o = count_r[0];
  assign rx_data_clk_o = count_r[2];
  assign rx_lr_clk_o   = count_r[8];

  // Phase 110 sees the pin as it was on the bit-clock rising edge (phase 100),
  // after the two synchronizer stages.
  always_comb begin
    capture = (phase == 3'd6) && (bit_idx >= 5'd1) && (bit_idx <= last_bit_lp);
    push    = (phase == 3'd7) && (bit_idx == last_bit_lp);
    full    = (occ_r == depth_lp);
    pop     = valid_o && ready_i;
    accept  = push && (!full || pop);
    drop    = push && full && !pop;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_r <= '0;
      sync_r  <= '0;
      shift_r <= '0;
    end else begin
      count_r <= count_r + 9'd1;
      sync_r  <= {sync_r[0], rx_data_i};
      if (capture) shift_r <= {shift_r[width_p-2:0], sync_r[1]};
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned i = 0; i < fifo_depth_p; i++) mem_r[i] <= '0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      occ_r      <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (accept) begin
        mem_r[wr_ptr_r] <= {ch, shift_r};
        wr_ptr_r        <= wr_ptr_r + ptr_w_lp'(1);
      end
      if (pop) rd_ptr_r <= rd_ptr_r + ptr_w_lp'(1);
      case ({accept, pop})
        2'b10:   occ_r <= occ_r + (ptr_w_lp+1)'(1);
        2'b01:   occ_r <= occ_r - (ptr_w_lp+1)'(1);
        default: occ_r <= occ_r;
      endcase
      if (drop) overflow_r <= 1'b1;
    end
  end

  assign valid_o    = (occ_r != '0);
  assign data_o     = mem_r[rd_ptr_r][width_p-1:0];
  assign last_o     = mem_r[rd_ptr_r][width_p];
  assign overflow_o = overflow_r;

`ifdef I2S_RX_OVF_COUNT_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                      ovf_count_o <= '0;
    else if (drop && ovf_count_o != '1)  ovf_count_o <= ovf_count_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_i2s_rx_deser.sv
// Self-checking bench for i2s_rx_deser: codec model, scoreboard of expected
// words, frame table, and sequences for backpressure, overflow and reset.
module tb_i2s_rx_deser;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic        pad;
    logic        exp_l;
    logic        exp_r;
  } frame_t;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        rx_main_clk_o, rx_data_clk_o, rx_lr_clk_o;
  logic        rx_data_i;
  logic [23:0] data_o;
  logic        valid_o, ready_i, last_o, overflow_o;
`ifdef I2S_RX_OVF_COUNT_EN
  logic [15:0] ovf_count_o;
`endif

  i2s_rx_deser #(.width_p(24), .fifo_depth_p(4)) dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .rx_main_clk_o (rx_main_clk_o),
    .rx_data_clk_o (rx_data_clk_o),
    .rx_lr_clk_o   (rx_lr_clk_o),
    .rx_data_i     (rx_data_i),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .last_o        (last_o),
    .overflow_o    (overflow_o)
`ifdef I2S_RX_OVF_COUNT_EN
    ,
    .ovf_count_o   (ovf_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  frame_t      frame_q[$];
  logic [24:0] sb[$];
  frame_t      cur;
  frame_t      tbl[4];
  int unsigned frame_no = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [8:0]  tcnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame position, used only to time the codec and the test steps.
  always @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) tcnt <= '0;
    else            tcnt <= tcnt + 9'd1;

  function automatic logic codec_bit(input logic [8:0] c, input frame_t f);
    logic [4:0]  b;
    logic [23:0] s;
    b = c[7:3];
    s = c[8] ? f.r : f.l;
    if (b >= 5'd1 && b <= 5'd24) return s[5'd24 - b];
    return f.pad;
  endfunction

  // Codec model: new frame at slot start, bit changes just after each clk edge.
  always @(posedge clk_i) begin
    #1;
    if (reset_n_i && tcnt == 9'd1) begin
      if (frame_q.size() > 0) cur = frame_q.pop_front();
      else cur = '{l: 24'h0, r: 24'h0, pad: 1'b0, exp_l: 1'b1, exp_r: 1'b1};
      if (cur.exp_l) sb.push_back({1'b0, cur.l});
      if (cur.exp_r) sb.push_back({1'b1, cur.r});
      frame_no++;
    end
    rx_data_i = codec_bit(tcnt, cur);
  end

  logic [24:0] held;
  logic        hold_v = 1'b0;

  always @(negedge clk_i) begin
    if (!reset_n_i) hold_v = 1'b0;
    else begin
      if (hold_v) check("hold_stable", {valid_o, last_o, data_o}, {1'b1, held});
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word: got %h expected none", {last_o, data_o});
        end else check("word", {last_o, data_o}, sb.pop_front());
      end
      hold_v = valid_o && !ready_i;
      held   = {last_o, data_o};
    end
  end

  task automatic wait_neg(input int unsigned fr, input int unsigned c);
    int unsigned budget = 0;
    bit          hit    = 0;
    while (!hit && budget < 6000) begin
      @(negedge clk_i);
      budget++;
      hit = (frame_no == fr) && (tcnt == c[8:0]);
    end
    if (!hit) check("timeout_neg", 64'(c), 64'(tcnt));
  endtask

  task automatic wait_pos(input int unsigned fr, input int unsigned c);
    int unsigned budget = 0;
    bit          hit    = 0;
    while (!hit && budget < 6000) begin
      @(posedge clk_i);
      #2;
      budget++;
      hit = (frame_no == fr) && (tcnt == c[8:0]);
    end
    if (!hit) check("timeout_pos", 64'(c), 64'(tcnt));
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({rx_main_clk_o, rx_data_clk_o, rx_lr_clk_o, valid_o, last_o, overflow_o, data_o});
  endfunction

  int unsigned base;
  int unsigned mm_main, mm_data, mm_lr;
  logic [8:0]  kv;

  initial begin
    cur       = '{l: 24'h0, r: 24'h0, pad: 1'b0, exp_l: 1'b1, exp_r: 1'b1};
    rx_data_i = 1'b0;
    ready_i   = 1'b1;
    reset_n_i = 1'b0;
    tbl[0] = '{l: 24'hABCDEF, r: 24'h123456, pad: 1'b0, exp_l: 1'b1, exp_r: 1'b1};
    tbl[1] = '{l: 24'h000001, r: 24'h000001, pad: 1'b1, exp_l: 1'b1, exp_r: 1'b1};
    tbl[2] = '{l: 24'h800000, r: 24'h7FFFFF, pad: 1'b1, exp_l: 1'b1, exp_r: 1'b1};
    tbl[3] = '{l: 24'hFFFFFF, r: 24'h000000, pad: 1'b0, exp_l: 1'b1, exp_r: 1'b1};
    repeat (3) @(negedge clk_i);
    check("por_outputs", all_outs(), 64'h0);
    reset_n_i = 1'b1;

    // Frame table; first entry also checks valid latency on both channels.
    wait_pos(1, 460);
    base = frame_no;
    for (int i = 0; i < 4; i++) frame_q.push_back(tbl[i]);
    wait_neg(base + 1, 199); check("lat_l_before", 64'(valid_o), 64'h0);
    wait_neg(base + 1, 200); check("lat_l_rise",   64'(valid_o), 64'h1);
    wait_neg(base + 1, 455); check("lat_r_before", 64'(valid_o), 64'h0);
    wait_neg(base + 1, 456); check("lat_r_rise",   64'(valid_o), 64'h1);

    // Full FIFO with a pop on each push cycle: nothing is dropped.
    wait_pos(base + 4, 460);
    base    = frame_no;
    ready_i = 1'b0;
    frame_q.push_back('{l: 24'h111111, r: 24'h222222, pad: 1'b0, exp_l: 1'b1, exp_r: 1'b1});
    frame_q.push_back('{l: 24'h333333, r: 24'h444444, pad: 1'b1, exp_l: 1'b1, exp_r: 1'b1});
    frame_q.push_back('{l: 24'h555555, r: 24'h666666, pad: 1'b0, exp_l: 1'b1, exp_r: 1'b1});
    wait_pos(base + 3, 199); ready_i = 1'b1;
    wait_pos(base + 3, 200); ready_i = 1'b0;
    wait_pos(base + 3, 455); ready_i = 1'b1;
    wait_pos(base + 3, 456); ready_i = 1'b0;
    wait_neg(base + 3, 460);
    check("pushpop_full_ovf", 64'(overflow_o), 64'h0);
    check("pushpop_full_valid", 64'(valid_o), 64'h1);
`ifdef I2S_RX_OVF_COUNT_EN
    check("pushpop_full_cnt", 64'(ovf_count_o), 64'h0);
`endif
    wait_pos(base + 3, 461); ready_i = 1'b1;

    // Three frames under backpressure: the third frame is dropped.
    wait_pos(base + 3, 480);
    base    = frame_no;
    ready_i = 1'b0;
    frame_q.push_back('{l: 24'hA00001, r: 24'hB00001, pad: 1'b0, exp_l: 1'b1, exp_r: 1'b1});
    frame_q.push_back('{l: 24'hA00002, r: 24'hB00002, pad: 1'b1, exp_l: 1'b1, exp_r: 1'b1});
    frame_q.push_back('{l: 24'hA00003, r: 24'hB00003, pad: 1'b0, exp_l: 1'b0, exp_r: 1'b0});
    wait_neg(base + 3, 199); check("ovf_before_drop", 64'(overflow_o), 64'h0);
    wait_neg(base + 3, 200); check("ovf_after_drop",  64'(overflow_o), 64'h1);
    wait_pos(base + 3, 460);
`ifdef I2S_RX_OVF_COUNT_EN
    check("ovf_count_two", 64'(ovf_count_o), 64'h2);
`endif
    ready_i = 1'b1;
    wait_neg(base + 3, 470); check("drained_four", 64'(valid_o), 64'h0);

    // Reset in the middle of a left slot; that frame must produce nothing.
    wait_pos(base + 3, 480);
    base = frame_no;
    frame_q.push_back('{l: 24'h5A5A5A, r: 24'hA5A5A5, pad: 1'b0, exp_l: 1'b0, exp_r: 1'b0});
    wait_pos(base + 1, 10);
    frame_q.push_back('{l: 24'hC0FFEE, r: 24'hBEEF01, pad: 1'b1, exp_l: 1'b1, exp_r: 1'b1});
    wait_pos(base + 1, 99);
    reset_n_i = 1'b0;
    #1;
    check("reset_outputs", all_outs(), 64'h0);
`ifdef I2S_RX_OVF_COUNT_EN
    check("reset_ovf_count", 64'(ovf_count_o), 64'h0);
`endif
    repeat (3) @(negedge clk_i);
    reset_n_i = 1'b1;
    mm_main = 0; mm_data = 0; mm_lr = 0;
    for (int unsigned k = 1; k <= 1100; k++) begin
      @(negedge clk_i);
      kv = 9'(k);
      if (rx_main_clk_o !== kv[0]) mm_main++;
      if (rx_data_clk_o !== kv[2]) mm_data++;
      if (rx_lr_clk_o   !== kv[8]) mm_lr++;
    end
    check("main_clk_pattern", 64'(mm_main), 64'h0);
    check("data_clk_pattern", 64'(mm_data), 64'h0);
    check("lr_clk_pattern",   64'(mm_lr),   64'h0);
    check("ovf_after_reset",  64'(overflow_o), 64'h0);
    wait_neg(frame_no, 470);
    check("scoreboard_empty", 64'(sb.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
